// File: rtl/ex_muldiv_sequencer.sv
// Iterative radix-2 multiply/divide unit for the EX stage: MULT/MULTU/DIV/DIVU into HI/LO,
// one shift-add or restoring-divide step per cycle, holding the pipeline via stall.
module ex_muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t             state, state_nxt;
   logic [2*WIDTH-1:0] acc;          // mult: {partial product, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic               sign_a, sign_b, is_div, dbz;
   logic [CNT_W-1:0]   count;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic use_sign);
      logic signed [WIDTH-1:0] sv;
      sv = v;
      return (use_sign && sv < 0) ? WIDTH'(-sv) : v;
   endfunction

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
      logic signed [WIDTH-1:0] sv;
      sv = v;
      return neg ? WIDTH'(-sv) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_wide_if(input logic [2*WIDTH-1:0] v, input logic neg);
      logic signed [2*WIDTH-1:0] sv;
      sv = v;
      return neg ? (2*WIDTH)'(-sv) : v;
   endfunction

   logic [WIDTH:0]     mult_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] step_nxt;
   logic [2*WIDTH-1:0] result;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   always_comb begin
      mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, mag_b};
      div_diff  = div_shift - {1'b0, mag_b};
      if (is_div)
         step_nxt = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
      else
         step_nxt = {mult_sum, acc[WIDTH-1:1]};
   end

   // Sign fix-up; a zero divisor keeps the all-ones quotient and returns the dividend as remainder
   always_comb begin
      quo_fix = dbz ? '1 : neg_if(acc[WIDTH-1:0], sign_a ^ sign_b);
      rem_fix = neg_if(acc[2*WIDTH-1:WIDTH], sign_a);
      result  = is_div ? {rem_fix, quo_fix} : neg_wide_if(acc, sign_a ^ sign_b);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !flush) state_nxt = RUN;
         RUN:     if (flush) state_nxt = IDLE;
                  else if (count == '0) state_nxt = FIX;
         FIX:     state_nxt = flush ? IDLE : DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         acc    <= '0;
         mag_a  <= '0;
         mag_b  <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         is_div <= 1'b0;
         dbz    <= 1'b0;
         count  <= '0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt == RUN) begin
            mag_a  <= magnitude(rs_val, !op[0]);
            mag_b  <= magnitude(rt_val, !op[0]);
            sign_a <= !op[0] && rs_val[WIDTH-1];
            sign_b <= !op[0] && rt_val[WIDTH-1];
            is_div <= op[1];
            dbz    <= op[1] && (rt_val == '0);
            count  <= CNT_W'(WIDTH-1);
            acc    <= op[1] ? {{WIDTH{1'b0}}, magnitude(rs_val, !op[0])}
                            : {{WIDTH{1'b0}}, magnitude(rt_val, !op[0])};
         end else if (state == RUN) begin
            acc   <= step_nxt;
            count <= count - 1'b1;
         end
         if (state == FIX && state_nxt == DONE) begin
            hi <= result[2*WIDTH-1:WIDTH];
            lo <= result[WIDTH-1:0];
         end
      end
   end

   assign busy        = (state == RUN) || (state == FIX);
   assign stall       = busy || (state == IDLE && start);
   assign done        = (state == DONE);
   assign div_by_zero = (state == DONE) && dbz;

endmodule
